rs_slot_allocator: RTL and testbench
====================================

# rs_slot_allocator

Stateful reservation-station slot allocator; a parametrised successor to the combinational two-way unused-slot picker. Owns the RS occupancy bitmap, grants up to WRITE_PORTS free slots per cycle to dispatch through a ready/request handshake, and reclaims up to ISSUE_PORTS slots per cycle from issue. A rotating search pointer spreads allocation across the array. Flush frees every slot. Sits between the dispatch stage and the RS entry array.

## Interface
- RS_SIZE, 8: number of RS entries; need not be a power of two.
- RS_INDEX_WIDTH, 3: slot index width; must be at least $clog2(RS_SIZE).
- WRITE_PORTS, 2: allocation ports per cycle, 1..RS_SIZE.
- ISSUE_PORTS, 2: free ports per cycle.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  free all slots; overrides everything else.
- alloc_req_i  in  WRITE_PORTS  per-port allocation request.
- alloc_ready_o  out  WRITE_PORTS  port k has a slot this cycle.
- alloc_index_o  out  WRITE_PORTS*RS_INDEX_WIDTH  slot for port k, packed at bits [k*RS_INDEX_WIDTH +: RS_INDEX_WIDTH].
- free_valid_i  in  ISSUE_PORTS  per-port free strobe.
- free_index_i  in  ISSUE_PORTS*RS_INDEX_WIDTH  slot to free, packed the same way.
- unused_o  out  RS_SIZE  registered bitmap, 1 = free.
- free_count_o  out  $clog2(RS_SIZE+1)  registered free-slot count.
- full_o  out  1  free_count_o == 0.
- empty_o  out  1  free_count_o == RS_SIZE.

## Operation
- State: unused bitmap, free count, search pointer ptr (0..RS_SIZE-1).
- Slot candidates: scan the bitmap from ptr upward, wrapping at RS_SIZE-1 to 0. Candidate k is the (k+1)-th free slot found.
- Ready: alloc_ready_o[k] = 1 iff free_count >= k+1. When ready, alloc_index_o[k] = candidate k; otherwise alloc_index_o[k] = 0.
- Ready and index depend only on registered state. There is no combinational path from alloc_req_i, free_*_i or flush_i to any output.
- Grant: port k is granted when alloc_req_i[k] && alloc_ready_o[k]. A granted slot is marked used at the next edge.
- Requests are not compacted. Port k always maps to candidate k. A request on an unready port is dropped; the requester retries.
- Pointer: if any grant, ptr <= (slot of highest-numbered granted port + 1) mod RS_SIZE, with an explicit wrap for non-power-of-two sizes. No grant leaves ptr unchanged.
- Free: for each free_valid_i[j] with free_index_i[j] < RS_SIZE, that slot is marked unused at the next edge.
  - Out-of-range indices are ignored.
  - Freeing an already-free slot is ignored.
  - Duplicate indices in one cycle count once.
- Simultaneous alloc and free in one cycle:
  - They always touch disjoint slots, because grants only use currently-free slots.
  - Next count = count − grants + slots newly freed.
  - A slot freed this cycle is not allocatable until the next cycle.
- Flush: at the next edge, bitmap becomes all ones, count = RS_SIZE and ptr = 0. Grants and frees in the flush cycle are discarded.
- Count is maintained incrementally and must always equal the popcount of the bitmap.

## Timing
- Reset (async assert, sync deassert handled externally):
  - unused_o = all ones, free_count_o = RS_SIZE, ptr = 0.
  - empty_o = 1, full_o = 0.
  - alloc_ready_o = all ones; alloc_index_o[k] = k.
- Allocation latency: grant in cycle N; slot cleared in unused_o and count updated in cycle N+1.
- Free latency: strobe in cycle N; slot visible as free and allocatable in cycle N+1.
- Full: alloc_ready_o = 0; requests have no effect. Empty: all ports ready when RS_SIZE >= WRITE_PORTS.
- Reset asserted mid-operation: state returns to reset values immediately. In-flight grants are lost and dispatch must replay.
- Throughput: WRITE_PORTS allocations and ISSUE_PORTS frees every cycle, sustained.

## Test plan
All scenarios use defaults RS_SIZE=8, WRITE_PORTS=2, ISSUE_PORTS=2.
- Reset, alloc_req_i=2'b11 for one cycle:
  - Granted indices 0 and 1.
  - Next cycle: unused_o=8'b11111100, free_count_o=6, alloc_index_o = {3,2}.
- alloc_req_i=2'b11 held for 4 cycles from reset:
  - Grants (0,1), (2,3), (4,5), (6,7).
  - Then full_o=1, alloc_ready_o=2'b00, ptr=0; further requests do not change state.
- From full with ptr=0, free slots 5 and 0 in one cycle:
  - Next cycle: ready=2'b11, indices {5,0}.
  - Request port 0 only: slot 0 granted, ptr=1, next cycle alloc_ready_o=2'b01 with index 5.
- Free slots 6,7,0 with ptr=6 and count 3; in one cycle alloc_req_i=2'b11 and free slot 3:
  - Grants 6 and 7.
  - Next cycle: unused_o=8'b00001001, count 2, ptr=0.
- Mid-fill state, alloc_req_i=2'b11 together with flush_i=1:
  - Next cycle: unused_o=8'hFF, count 8, ptr=0, empty_o=1; no slot consumed.
- Slot 2 occupied, free_index_i both = 2: count increases by exactly 1. Then free slot 2 again and free index 9 (out of range): no state change.

Source files
------------

// File: rtl/rs_slot_allocator.sv
// rs_slot_allocator
//   Stateful reservation-station slot allocator. Owns the RS occupancy bitmap,
//   offers up to WRITE_PORTS free slots per cycle to dispatch, and reclaims up
//   to ISSUE_PORTS slots per cycle from issue. A rotating search pointer
//   spreads allocation across the array. Flush frees every slot.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   flush_i        free all slots, overrides grants and frees
//   alloc_req_i    per-port allocation request
//   alloc_ready_o  port k has a slot this cycle
//   alloc_index_o  slot for port k at [k*RS_INDEX_WIDTH +: RS_INDEX_WIDTH]
//   free_valid_i   per-port free strobe
//   free_index_i   slot to free, packed like alloc_index_o
//   unused_o       registered bitmap, 1 = free
//   free_count_o   registered free-slot count
//   full_o         no free slot
//   empty_o        every slot free
module rs_slot_allocator #(
    parameter int unsigned RS_SIZE        = 8,
    parameter int unsigned RS_INDEX_WIDTH = 3,
    parameter int unsigned WRITE_PORTS    = 2,
    parameter int unsigned ISSUE_PORTS    = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic [WRITE_PORTS-1:0]                alloc_req_i,
    output logic [WRITE_PORTS-1:0]                alloc_ready_o,
    output logic [WRITE_PORTS*RS_INDEX_WIDTH-1:0] alloc_index_o,
    input  logic [ISSUE_PORTS-1:0]                free_valid_i,
    input  logic [ISSUE_PORTS*RS_INDEX_WIDTH-1:0] free_index_i,
    output logic [RS_SIZE-1:0]                    unused_o,
    output logic [$clog2(RS_SIZE+1)-1:0]          free_count_o,
    output logic                                  full_o,
    output logic                                  empty_o
);

    localparam int unsigned CW = $clog2(RS_SIZE + 1);
    localparam int unsigned IW = RS_INDEX_WIDTH;

    logic [RS_SIZE-1:0]     r_unused;
    logic [CW-1:0]          r_count;
    logic [IW-1:0]          r_ptr;

    logic [IW-1:0]          w_cand [WRITE_PORTS];
    logic [WRITE_PORTS-1:0] w_ready;
    logic [WRITE_PORTS-1:0] w_grant;
    logic [RS_SIZE-1:0]     w_alloc_mask;
    logic [RS_SIZE-1:0]     w_free_mask;
    logic [RS_SIZE-1:0]     w_unused_nxt;
    logic [CW-1:0]          w_count_nxt;
    logic [IW-1:0]          w_ptr_nxt;

    // Candidate k is the (k+1)-th free slot found scanning upward from r_ptr
    // with wrap at RS_SIZE-1. Explicit subtract handles non-power-of-two sizes.
    always_comb begin : cand_search
        int unsigned found;
        int unsigned slot;
        found = 0;
        slot  = 0;
        for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
            w_cand[k] = '0;
        end
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            slot = 32'(r_ptr) + i;
            if (slot >= RS_SIZE) begin
                slot = slot - RS_SIZE;
            end
            if (r_unused[slot]) begin
                for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
                    if (found == k) begin
                        w_cand[k] = IW'(slot);
                    end
                end
                found = found + 1;
            end
        end
    end

    // Ready and index come from registered state only; requests never feed back.
    always_comb begin : ready_index
        w_ready       = '0;
        alloc_index_o = '0;
        for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
            w_ready[k] = (32'(r_count) > k);
            if (w_ready[k]) begin
                alloc_index_o[k*IW +: IW] = w_cand[k];
            end
        end
        w_grant = alloc_req_i & w_ready;
    end

    always_comb begin : next_state
        int unsigned   n_alloc;
        int unsigned   n_free;
        int unsigned   last;
        logic          any_grant;
        logic [IW-1:0] fidx;
        w_alloc_mask = '0;
        w_free_mask  = '0;
        last         = 0;
        any_grant    = 1'b0;
        fidx         = '0;

        // Ports map to candidates in order, so the last granted port holds the
        // highest-numbered granted slot position for the pointer update.
        for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
            if (w_grant[k]) begin
                w_alloc_mask[w_cand[k]] = 1'b1;
                last                    = 32'(w_cand[k]);
                any_grant               = 1'b1;
            end
        end

        // Only slots in use at the start of the cycle can be freed; this keeps
        // frees disjoint from grants and makes duplicates count once.
        for (int unsigned j = 0; j < ISSUE_PORTS; j++) begin
            fidx = free_index_i[j*IW +: IW];
            if (free_valid_i[j] && (32'(fidx) < RS_SIZE)) begin
                if (!r_unused[fidx]) begin
                    w_free_mask[fidx] = 1'b1;
                end
            end
        end

        n_alloc = $countones(w_alloc_mask);
        n_free  = $countones(w_free_mask);

        w_unused_nxt = (r_unused & ~w_alloc_mask) | w_free_mask;
        w_count_nxt  = CW'(32'(r_count) - n_alloc + n_free);
        w_ptr_nxt    = r_ptr;
        if (any_grant) begin
            w_ptr_nxt = (last + 1 >= RS_SIZE) ? '0 : IW'(last + 1);
        end

        if (flush_i) begin
            w_unused_nxt = '1;
            w_count_nxt  = CW'(RS_SIZE);
            w_ptr_nxt    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_unused <= '1;
            r_count  <= CW'(RS_SIZE);
            r_ptr    <= '0;
        end else begin
            r_unused <= w_unused_nxt;
            r_count  <= w_count_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign alloc_ready_o = w_ready;
    assign unused_o      = r_unused;
    assign free_count_o  = r_count;
    assign full_o        = (r_count == '0);
    assign empty_o       = (r_count == CW'(RS_SIZE));

endmodule

// File: tb/tb_rs_slot_allocator.sv
// tb_rs_slot_allocator
//   Self-checking bench for rs_slot_allocator (RS_SIZE=8, 2 write, 2 issue
//   ports). Index width is 4 so out-of-range free indices can be driven.
//   Expected outputs come from a small reference model, queued when stimulus
//   is driven and compared after the clock edge.
module tb_rs_slot_allocator;

    localparam int unsigned RS = 8;
    localparam int unsigned IW = 4;

    typedef struct packed {
        logic [7:0] unused;
        logic [3:0] count;
        logic [1:0] ready;
        logic [7:0] index;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] req;
    logic [1:0] ready;
    logic [7:0] index;
    logic [1:0] fv;
    logic [7:0] fidx;
    logic [7:0] unused;
    logic [3:0] count;
    logic       full;
    logic       empty;

    int unsigned n_checks;
    int unsigned n_errors;

    exp_t        sb_q[$];
    logic [7:0]  m_unused;
    int unsigned m_ptr;

    rs_slot_allocator #(
        .RS_SIZE       (RS),
        .RS_INDEX_WIDTH(IW),
        .WRITE_PORTS   (2),
        .ISSUE_PORTS   (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .alloc_req_i  (req),
        .alloc_ready_o(ready),
        .alloc_index_o(index),
        .free_valid_i (fv),
        .free_index_i (fidx),
        .unused_o     (unused),
        .free_count_o (count),
        .full_o       (full),
        .empty_o      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs implied by the model state: free slots listed in search order.
    function automatic exp_t model_out();
        exp_t        e;
        int unsigned q[$];
        for (int unsigned i = 0; i < RS; i++) begin
            int unsigned s;
            s = (m_ptr + i) % RS;
            if (m_unused[s]) q.push_back(s);
        end
        e.unused = m_unused;
        e.count  = 4'(q.size());
        e.ready  = '0;
        e.index  = '0;
        for (int k = 0; k < 2; k++) begin
            if (q.size() > k) begin
                e.ready[k]         = 1'b1;
                e.index[k*4 +: 4]  = 4'(q[k]);
            end
        end
        return e;
    endfunction

    task automatic compare_out(input string tag, input exp_t e);
        check({tag, "_unused"}, 32'(unused), 32'(e.unused));
        check({tag, "_count"},  32'(count),  32'(e.count));
        check({tag, "_ready"},  32'(ready),  32'(e.ready));
        check({tag, "_index"},  32'(index),  32'(e.index));
        check({tag, "_full"},   32'(full),   32'(e.count == 4'd0));
        check({tag, "_empty"},  32'(empty),  32'(e.count == 4'd8));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_unused"}, 32'(unused), 32'hFF);
        check({tag, "_count"},  32'(count),  32'd8);
        check({tag, "_ready"},  32'(ready),  32'h3);
        check({tag, "_index"},  32'(index),  32'h10);
        check({tag, "_empty"},  32'(empty),  32'd1);
        check({tag, "_full"},   32'(full),   32'd0);
    endtask

    // One clock: drive inputs, advance the model, queue the expectation,
    // clock, then compare the DUT against the popped expectation.
    task automatic cyc(input logic f, input logic [1:0] r, input logic [1:0] v,
                       input logic [3:0] i0, input logic [3:0] i1);
        exp_t        cur;
        exp_t        e;
        logic [7:0]  nu;
        int unsigned last;
        logic        any;
        logic [3:0]  fi [2];
        flush = f;
        req   = r;
        fv    = v;
        fidx  = {i1, i0};
        fi[0] = i0;
        fi[1] = i1;
        cur   = model_out();
        nu    = m_unused;
        last  = 0;
        any   = 1'b0;
        if (f) begin
            m_unused = 8'hFF;
            m_ptr    = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (r[k] && cur.ready[k]) begin
                    nu[cur.index[k*4 +: 3]] = 1'b0;
                    last = 32'(cur.index[k*4 +: 4]);
                    any  = 1'b1;
                end
            end
            // A free only counts for a slot that was in use before this edge.
            for (int j = 0; j < 2; j++) begin
                if (v[j] && fi[j] < 4'd8 && !m_unused[fi[j][2:0]]) nu[fi[j][2:0]] = 1'b1;
            end
            m_unused = nu;
            if (any) m_ptr = (last + 1) % RS;
        end
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        flush = 1'b0;
        req   = '0;
        fv    = '0;
        fidx  = '0;
        e = sb_q.pop_front();
        compare_out("sb", e);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        req      = '0;
        fv       = '0;
        fidx     = '0;
        m_unused = 8'hFF;
        m_ptr    = 0;

        #12;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two grants from reset take slots 0 and 1.
        cyc(1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
        check("first_unused", 32'(unused), 32'hFC);
        check("first_count",  32'(count),  32'd6);
        check("first_index",  32'(index),  32'h32);

        // Fill to full, then requests have no effect.
        repeat (3) cyc(1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
        check("fill_full",  32'(full),  32'd1);
        check("fill_ready", 32'(ready), 32'd0);
        cyc(1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
        check("full_hold_unused", 32'(unused), 32'h00);

        // Free 5 and 0 at ptr 0: candidates are 0 then 5.
        cyc(1'b0, 2'b00, 2'b11, 4'd5, 4'd0);
        check("free50_ready", 32'(ready), 32'h3);
        check("free50_index", 32'(index), 32'h50);
        cyc(1'b0, 2'b01, 2'b00, 4'd0, 4'd0);
        check("port0_ready", 32'(ready), 32'h1);
        check("port0_index", 32'(index), 32'h05);

        // Build ptr=6 with slots 6,7,0 free, then grant 6,7 while freeing 3.
        cyc(1'b1, 2'b00, 2'b00, 4'd0, 4'd0);
        repeat (3) cyc(1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
        cyc(1'b0, 2'b00, 2'b01, 4'd0, 4'd0);
        check("wrap_pre_count", 32'(count), 32'd3);
        cyc(1'b0, 2'b11, 2'b01, 4'd3, 4'd0);
        check("wrap_unused", 32'(unused), 32'h09);
        check("wrap_count",  32'(count),  32'd2);
        check("wrap_index",  32'(index),  32'h30);

        // Flush wins over simultaneous requests.
        cyc(1'b1, 2'b11, 2'b00, 4'd0, 4'd0);
        check("flush_unused", 32'(unused), 32'hFF);
        check("flush_count",  32'(count),  32'd8);
        check("flush_empty",  32'(empty),  32'd1);
        check("flush_index",  32'(index),  32'h10);

        // Duplicate free counts once; re-free and out-of-range are ignored.
        cyc(1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
        cyc(1'b0, 2'b01, 2'b00, 4'd0, 4'd0);
        check("dup_pre_count", 32'(count), 32'd5);
        cyc(1'b0, 2'b00, 2'b11, 4'd2, 4'd2);
        check("dup_count", 32'(count), 32'd6);
        cyc(1'b0, 2'b00, 2'b11, 4'd2, 4'd9);
        check("refree_count",  32'(count),  32'd6);
        check("refree_unused", 32'(unused), 32'hFC);

        // Random traffic against the model.
        repeat (300) begin
            cyc(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
        end

        // Asynchronous reset mid-cycle returns to reset state at once.
        cyc(1'b0, 2'b11, 2'b00, 4'd0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        m_unused = 8'hFF;
        m_ptr    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (60) begin
            cyc(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
